// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single memory unit.
// Optional `MEM_ARBITER_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic [2:0]  f_fault,
  input  logic        d_req,
  input  logic        d_is_write,
  input  logic        d_is_unsigned,
  input  logic [1:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [2:0]  d_fault,
  output logic        m_available,
  output logic        m_is_write,
  output logic        m_is_unsigned,
  output logic [1:0]  m_op,
  output logic [31:0] m_addr,
  output logic [31:0] m_in,
  input  logic [31:0] m_out,
  input  logic        m_busy,
  input  logic        m_op_fault,
  input  logic        m_addr_fault,
  input  logic        m_access_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic        owner;
  logic [2:0]  sticky;
  logic        grant_data;
  logic        finish;
  logic [2:0]  cur_fault;
  logic [2:0]  fin_fault;
  logic [31:0] fin_rdata;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_served;

  always_comb begin
    grant_data = d_req && (!f_req || !last_served);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= 1'b0;
    end else if (state == S_DONE) begin
      last_served <= owner;
    end
  end
`else
  always_comb begin
    grant_data = d_req;
  end
`endif

  // Completion is decided combinationally so the done outputs can be registered
  // on the same edge that moves the FSM into DONE.
  always_comb begin
    cur_fault = {m_op_fault, m_addr_fault, m_access_fault};
    finish    = ((state == S_ISSUE) || (state == S_WAIT)) && !m_busy;
    fin_fault = sticky | cur_fault;
    fin_rdata = (state == S_WAIT) ? m_out : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      sticky        <= '0;
      m_available   <= 1'b0;
      m_is_write    <= 1'b0;
      m_is_unsigned <= 1'b0;
      m_op          <= '0;
      m_addr        <= '0;
      m_in          <= '0;
      f_done        <= 1'b0;
      f_rdata       <= '0;
      f_fault       <= '0;
      d_done        <= 1'b0;
      d_rdata       <= '0;
      d_fault       <= '0;
    end else begin
      f_done  <= 1'b0;
      f_rdata <= '0;
      f_fault <= '0;
      d_done  <= 1'b0;
      d_rdata <= '0;
      d_fault <= '0;
      case (state)
        S_IDLE: begin
          if (f_req || d_req) begin
            owner       <= grant_data;
            m_available <= 1'b1;
            state       <= S_ISSUE;
            if (grant_data) begin
              m_is_write    <= d_is_write;
              m_is_unsigned <= d_is_unsigned;
              m_op          <= d_op;
              m_addr        <= d_addr;
              m_in          <= d_wdata;
            end else begin
              m_is_write    <= 1'b0;
              m_is_unsigned <= 1'b0;
              m_op          <= 2'b10;
              m_addr        <= f_addr;
              m_in          <= '0;
            end
          end
        end
        S_ISSUE: begin
          sticky <= fin_fault;
          state  <= m_busy ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          sticky <= fin_fault;
          if (!m_busy) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          sticky <= '0;
          state  <= S_IDLE;
        end
      endcase
      if (finish) begin
        m_available <= 1'b0;
        if (owner) begin
          d_done  <= 1'b1;
          d_rdata <= fin_rdata;
          d_fault <= fin_fault;
        end else begin
          f_done  <= 1'b1;
          f_rdata <= fin_rdata;
          f_fault <= fin_fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_done;
  logic [31:0] f_rdata;
  logic [2:0]  f_fault;
  logic        d_req;
  logic        d_is_write;
  logic        d_is_unsigned;
  logic [1:0]  d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [2:0]  d_fault;
  logic        m_available;
  logic        m_is_write;
  logic        m_is_unsigned;
  logic [1:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_in;
  logic [31:0] m_out;
  logic        m_busy;
  logic        m_op_fault;
  logic        m_addr_fault;
  logic        m_access_fault;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_fault(f_fault),
    .d_req(d_req), .d_is_write(d_is_write), .d_is_unsigned(d_is_unsigned), .d_op(d_op),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_fault(d_fault),
    .m_available(m_available), .m_is_write(m_is_write), .m_is_unsigned(m_is_unsigned),
    .m_op(m_op), .m_addr(m_addr), .m_in(m_in), .m_out(m_out), .m_busy(m_busy),
    .m_op_fault(m_op_fault), .m_addr_fault(m_addr_fault), .m_access_fault(m_access_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: busy for cfg_busy cycles after m_available rises, faults on one chosen cycle.
  int          cfg_busy = 0;
  int          cfg_fault_at = -1;
  logic [2:0]  cfg_fault = '0;
  logic [31:0] cfg_rdata = '0;
  int          mcnt = 0;

  always @(posedge clk) begin
    if (!m_available) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always_comb begin
    m_busy = m_available && (mcnt < cfg_busy);
    m_out  = cfg_rdata;
    {m_op_fault, m_addr_fault, m_access_fault} =
      (m_available && (mcnt == cfg_fault_at)) ? cfg_fault : 3'b000;
  end

  typedef struct {
    logic        w;
    logic        u;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    int          len;
  } grant_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic [2:0]  fault;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];

  function automatic grant_t fetch_g(input logic [31:0] a, input int len);
    grant_t g;
    g.w = 1'b0; g.u = 1'b0; g.op = 2'b10; g.addr = a; g.wd = '0; g.len = len;
    return g;
  endfunction

  function automatic grant_t data_g(input logic w, input logic u, input logic [1:0] op,
                                    input logic [31:0] a, input logic [31:0] wd, input int len);
    grant_t g;
    g.w = w; g.u = u; g.op = op; g.addr = a; g.wd = wd; g.len = len;
    return g;
  endfunction

  function automatic done_t mk_done(input logic is_data, input logic [31:0] rd, input logic [2:0] flt);
    done_t d;
    d.is_data = is_data; d.rdata = rd; d.fault = flt;
    return d;
  endfunction

  // Monitor
  logic   prev_av = 1'b0;
  logic   have_g = 1'b0;
  int     av_len = 0;
  grant_t cur_g;
  done_t  cur_d;

  always @(negedge clk) begin
    if (reset) begin
      prev_av = 1'b0;
      have_g  = 1'b0;
      av_len  = 0;
    end else begin
      if (m_available && !prev_av) begin
        av_len = 0;
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'd1, 32'd0);
          have_g = 1'b0;
        end else begin
          cur_g  = gq.pop_front();
          have_g = 1'b1;
        end
      end
      if (m_available && have_g) begin
        av_len++;
        check("m_ctrl", {28'd0, m_is_write, m_is_unsigned, m_op}, {28'd0, cur_g.w, cur_g.u, cur_g.op});
        check("m_addr", m_addr, cur_g.addr);
        check("m_in", m_in, cur_g.wd);
      end
      if (!m_available && prev_av && have_g) begin
        check("m_available_len", av_len, cur_g.len);
        have_g = 1'b0;
      end
      if (f_done && d_done) check("both_done", 32'd1, 32'd0);
      if (f_done || d_done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", {30'd0, f_done, d_done}, 32'd0);
        end else begin
          cur_d = dq.pop_front();
          check("done_owner", {30'd0, f_done, d_done}, {30'd0, !cur_d.is_data, cur_d.is_data});
          check("f_rdata", f_rdata, cur_d.is_data ? 32'd0 : cur_d.rdata);
          check("d_rdata", d_rdata, cur_d.is_data ? cur_d.rdata : 32'd0);
          check("f_fault", {29'd0, f_fault}, cur_d.is_data ? 32'd0 : {29'd0, cur_d.fault});
          check("d_fault", {29'd0, d_fault}, cur_d.is_data ? {29'd0, cur_d.fault} : 32'd0);
        end
      end
      prev_av = m_available;
    end
  end

  task automatic set_mem(input int busy, input int fat, input logic [2:0] flt, input logic [31:0] rd);
    cfg_busy = busy; cfg_fault_at = fat; cfg_fault = flt; cfg_rdata = rd;
  endtask

  task automatic wait_done(output logic was_data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(f_done || d_done) && n < 100);
    if (!(f_done || d_done)) check("done_timeout", 32'd0, 32'd1);
    was_data = d_done;
  endtask

  task automatic set_data(input logic w, input logic u, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] wd);
    d_is_write = w; d_is_unsigned = u; d_op = op; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wd_data;
    int   n;
    int   k;
    int   total;
    int   ndata;

    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0;
    set_data(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_m_available", {31'd0, m_available}, 32'd0);
    check("rst_dones", {30'd0, f_done, d_done}, 32'd0);
    check("rst_faults", {26'd0, f_fault, d_fault}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    reset = 1'b0;

    // Fetch, memory busy two cycles
    set_mem(2, -1, 3'b000, 32'hDEADBEEF);
    gq.push_back(fetch_g(32'h100, 3));
    dq.push_back(mk_done(1'b0, 32'hDEADBEEF, 3'b000));
    f_req = 1'b1; f_addr = 32'h100;
    wait_done(wd_data);
    f_req = 1'b0;

    // Half store with setup fault reported in ISSUE
    set_mem(0, 0, 3'b011, 32'h0);
    gq.push_back(data_g(1'b1, 1'b0, 2'b01, 32'h3, 32'h1234ABCD, 1));
    dq.push_back(mk_done(1'b1, 32'h0, 3'b011));
    set_data(1'b1, 1'b0, 2'b01, 32'h3, 32'h1234ABCD);
    d_req = 1'b1;
    wait_done(wd_data);
    d_req = 1'b0;

    // Byte load, op fault only during WAIT must stick to completion
    set_mem(3, 1, 3'b100, 32'h80FF1234);
    gq.push_back(data_g(1'b0, 1'b1, 2'b00, 32'h41, 32'h55, 4));
    dq.push_back(mk_done(1'b1, 32'h80FF1234, 3'b100));
    set_data(1'b0, 1'b1, 2'b00, 32'h41, 32'h55);
    d_req = 1'b1;
    wait_done(wd_data);
    d_req = 1'b0;

    // Clean fetch: sticky faults must have cleared
    set_mem(1, -1, 3'b000, 32'h12345678);
    gq.push_back(fetch_g(32'h204, 2));
    dq.push_back(mk_done(1'b0, 32'h12345678, 3'b000));
    f_req = 1'b1; f_addr = 32'h204;
    wait_done(wd_data);
    f_req = 1'b0;

    // Data request appearing in the fetch DONE cycle
    set_mem(1, -1, 3'b000, 32'hA5A5A5A5);
    gq.push_back(fetch_g(32'h300, 2));
    dq.push_back(mk_done(1'b0, 32'hA5A5A5A5, 3'b000));
    gq.push_back(data_g(1'b0, 1'b0, 2'b10, 32'h400, 32'h0, 2));
    dq.push_back(mk_done(1'b1, 32'hA5A5A5A5, 3'b000));
    f_req = 1'b1; f_addr = 32'h300;
    wait_done(wd_data);
    f_req = 1'b0;
    set_data(1'b0, 1'b0, 2'b10, 32'h400, 32'h0);
    d_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_available && n < 10);
    check("gap_cycles", n, 32'd2);
    wait_done(wd_data);
    d_req = 1'b0;

    // Reset during WAIT aborts without a done pulse
    set_mem(10, -1, 3'b000, 32'hFFFF0000);
    gq.push_back(fetch_g(32'h500, 0));
    f_req = 1'b1; f_addr = 32'h500;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_available && n < 10);
    check("abort_grant", {31'd0, m_available}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    f_req = 1'b0;
    @(negedge clk);
    check("abort_m_available", {31'd0, m_available}, 32'd0);
    check("abort_dones", {30'd0, f_done, d_done}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    set_mem(2, -1, 3'b000, 32'h600D600D);
    gq.push_back(fetch_g(32'h600, 3));
    dq.push_back(mk_done(1'b0, 32'h600D600D, 3'b000));
    f_req = 1'b1; f_addr = 32'h600;
    wait_done(wd_data);
    f_req = 1'b0;

    // Simultaneous requests
    set_mem(1, -1, 3'b000, 32'hC0DE0000);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    total = 4; ndata = 2;
    gq.push_back(data_g(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 2));
    gq.push_back(fetch_g(32'h700, 2));
    gq.push_back(data_g(1'b0, 1'b0, 2'b10, 32'h1004, 32'h0, 2));
    gq.push_back(fetch_g(32'h700, 2));
    dq.push_back(mk_done(1'b1, 32'hC0DE0000, 3'b000));
    dq.push_back(mk_done(1'b0, 32'hC0DE0000, 3'b000));
    dq.push_back(mk_done(1'b1, 32'hC0DE0000, 3'b000));
    dq.push_back(mk_done(1'b0, 32'hC0DE0000, 3'b000));
`else
    total = 5; ndata = 4;
    for (int i = 0; i < 4; i++) begin
      gq.push_back(data_g(1'b0, 1'b0, 2'b10, 32'h1000 + 32'(4 * i), 32'h0, 2));
      dq.push_back(mk_done(1'b1, 32'hC0DE0000, 3'b000));
    end
    gq.push_back(fetch_g(32'h700, 2));
    dq.push_back(mk_done(1'b0, 32'hC0DE0000, 3'b000));
`endif
    k = 0;
    set_data(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0);
    f_addr = 32'h700;
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < total; i++) begin
      wait_done(wd_data);
      if (wd_data) begin
        k++;
        d_addr = 32'h1000 + 32'(4 * k);
        if (k == ndata) d_req = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0;

    repeat (5) @(negedge clk);
    check("grant_queue_empty", gq.size(), 32'd0);
    check("done_queue_empty", dq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 f_req  in  1  fetch request; held high with f_addr stable until f_done.
REQ-005 f_addr  in  32  fetch address; fetch is always a word read.
REQ-006 f_done  out  1  one-cycle fetch completion pulse.
REQ-007 f_rdata  out  32  fetch read data; valid when f_done=1.
REQ-008 f_fault  out  3  {op,addr,access} faults; valid when f_done=1.
REQ-009 d_req  in  1  data request; held high with all d_* inputs stable until d_done.
REQ-010 d_is_write  in  1  1 = store, 0 = load.
REQ-011 d_is_unsigned  in  1  zero-extend narrow loads.
REQ-012 d_op  in  2  size: 00 = byte, 01 = half, 10 = word.
REQ-013 d_addr  in  32  data address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_done  out  1  one-cycle data completion pulse.
REQ-016 d_rdata  out  32  load data; valid when d_done=1.
REQ-017 d_fault  out  3  {op,addr,access} faults; valid when d_done=1.
REQ-018 m_available  out  1  operation available to the memory unit.
REQ-019 m_is_write, m_is_unsigned  out  1 each  forwarded from the granted requester.
REQ-020 m_op  out  2  forwarded size; 2'b10 for fetch.
REQ-021 m_addr, m_in  out  32 each  forwarded address and write data (m_in = 0 for fetch).
REQ-022 m_out  in  32  memory read result.
REQ-023 m_busy  in  1  memory operation busy.
REQ-024 m_op_fault, m_addr_fault, m_access_fault  in  1 each  memory faults.

Function
REQ-025 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, plus a 1-bit registered owner (0 = fetch, 1 = data).
- All m_* outputs SHALL be driven from registers latched at grant.
- The m_* outputs SHALL stay stable from ISSUE through WAIT.
REQ-026 IDLE: if any request is pending, the block SHALL latch the winner, set m_available=1 and go to ISSUE the next cycle. With no request it SHALL stay in IDLE with m_available=0.
REQ-027 ISSUE (first cycle after grant, m_available=1): the block SHALL OR m_*_fault into sticky fault flags.
- m_busy=1: go to WAIT.
- m_busy=0: go to DONE (setup fault; the memory never starts).
REQ-028 WAIT: the block SHALL hold m_available=1 and keep OR-ing faults. When m_busy=0, it SHALL capture m_out and go to DONE.
REQ-029 DONE: the block SHALL drive m_available=0 for exactly one cycle (so the memory unit's started flag clears).
- It SHALL pulse the owner's done with the captured rdata and sticky faults.
- It SHALL then clear the sticky faults and return to IDLE.
- The minimum transaction length is therefore 3 cycles from grant to done.
REQ-030 Done, rdata and fault outputs of the non-owner SHALL be 0. f_done and d_done SHALL never both be 1.
REQ-031 A request that arrives mid-transaction SHALL wait. Request inputs SHALL be ignored outside IDLE.
REQ-032 Simultaneous f_req and d_req in IDLE SHALL resolve per REQ-036.
REQ-033 A requester dropping req before done is a protocol violation; the transaction SHALL still run to DONE and the done pulse SHALL be issued.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL, on that edge:
- go to IDLE;
- drive m_available, f_done, d_done, all fault outputs and all sticky flags to 0;
- set the owner to fetch and the round-robin pointer to fetch.
Reset mid-transaction SHALL abort it without any done pulse.
REQ-035 All 32-bit data and address registers SHALL reset to 0.

Configuration
REQ-036 Macro MEM_ARBITER_ROUND_ROBIN_EN:
- Defined: on a simultaneous request, the block SHALL grant the requester that was not served last. The pointer SHALL update at DONE.
- Undefined: the data port SHALL always win a simultaneous request (fixed priority), and no pointer register SHALL exist.

Verification
REQ-037 f_req=1, f_addr=0x100, memory busy for 2 cycles, m_out=0xDEADBEEF -> m_op=10, m_available high 3 cycles, f_done pulse, f_rdata=0xDEADBEEF, f_fault=000.
REQ-038 d_req store, d_op=01, d_addr=0x3, memory reports m_addr_fault and m_access_fault with m_busy=0 -> DONE after ISSUE, d_done with d_fault=011, no f_done.
REQ-039 f_req and d_req asserted together for 4 transactions -> without the macro: D, D, D, D while d_req is held; with the macro: D, F, D, F.
REQ-040 reset asserted during WAIT -> the next cycle m_available=0, state IDLE, no done pulse; a new f_req is then served normally.
REQ-041 d_req arrives in the DONE cycle of a fetch -> granted from IDLE the following cycle; m_available is low for at least 1 cycle between the two transactions.
